// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants for the core datapath.
//   FUNCT3_*    : load/store access size and sign encodings.
//   lsu_state_t : sequencing states of the load/store memory interface.
package riscv_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_be_gen.sv
// lsu_be_gen: combinational byte-enable / store-data lane generator.
// Ports:
//   i_we          : 1 = store, 0 = load
//   i_funct3      : access size/sign
//   i_addr        : byte address (only [1:0] matter)
//   i_wdata       : store data, value in LSBs
//   o_be          : byte enables (zero for loads and faulting accesses)
//   o_wdata       : store data replicated across the byte lanes
//   o_misaligned  : access not naturally aligned for its size
//   o_illegal     : funct3 not supported for this direction
module lsu_be_gen
  import riscv_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [3:0] w_be_raw;

  always_comb begin
    w_be_raw     = 4'b0000;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      FUNCT3_B: begin
        w_be_raw = 4'b0001 << i_addr[1:0];
        o_wdata  = {4{i_wdata[7:0]}};
      end
      FUNCT3_H: begin
        w_be_raw     = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr[0];
      end
      FUNCT3_W: begin
        w_be_raw     = 4'b1111;
        o_misaligned = |i_addr[1:0];
      end
      // Unsigned variants exist only for loads; a store with them is illegal
      // and is not additionally reported as misaligned.
      FUNCT3_BU: begin
        o_illegal = i_we;
      end
      FUNCT3_HU: begin
        o_illegal    = i_we;
        o_misaligned = ~i_we & i_addr[0];
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
    // Loads read the whole word; faulting accesses never reach the bus.
    o_be = (i_we && !o_illegal && !o_misaligned) ? w_be_raw : 4'b0000;
  end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit to data-memory bus adapter.
// Accepts one request at a time from the pipeline, checks alignment and
// funct3 legality, issues a single word-aligned bus request (req/gnt
// handshake, then rvalid for loads) and returns a one-cycle completion
// pulse carrying the raw read word for the downstream load slicer.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready          : request handshake from the pipeline
//   req_we/req_funct3/req_addr/req_wdata : captured request fields
//   dmem_req/dmem_gnt            : bus request / grant
//   dmem_addr/we/be/wdata        : bus command, stable while dmem_req waits
//   dmem_rvalid/dmem_rdata       : bus read return
//   rsp_valid                    : one-cycle completion pulse
//   rsp_rdata/d_select/funct3    : raw word, addr[1:0], captured funct3
//   rsp_misaligned/rsp_illegal   : fault flags, valid with rsp_valid
//   busy                         : pipeline stall request
module lsu_mem_if
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_d_select,
  output logic [2:0]  rsp_funct3,
  output logic        rsp_misaligned,
  output logic        rsp_illegal,
  output logic        busy
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic        r_ill;
  logic [31:0] r_rdata;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic        w_ill;

  // Lane/fault generation is done on the incoming request so the bus command
  // is registered at accept and stays stable until granted.
  lsu_be_gen u_be_gen (
    .i_we         (req_we),
    .i_funct3     (req_funct3),
    .i_addr       (req_addr),
    .i_wdata      (req_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .o_illegal    (w_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LSU_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'h0;
      r_mis    <= 1'b0;
      r_ill    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_mis    <= w_mis;
            r_ill    <= w_ill;
            r_rdata  <= 32'h0;
            r_state  <= (w_mis || w_ill) ? LSU_RESP : LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (dmem_gnt) begin
            r_state <= r_we ? LSU_RESP : LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (dmem_rvalid) begin
            r_rdata <= dmem_rdata;
            r_state <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          r_state <= LSU_IDLE;
        end
        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = (r_state == LSU_IDLE);
  assign busy           = (r_state == LSU_REQ) || (r_state == LSU_WAIT) ||
                          ((r_state == LSU_IDLE) && req_valid);

  assign dmem_req       = (r_state == LSU_REQ);
  assign dmem_addr      = {r_addr[31:2], 2'b00};
  assign dmem_we        = dmem_req & r_we;
  assign dmem_be        = dmem_req ? r_be : 4'b0000;
  assign dmem_wdata     = r_wdata;

  assign rsp_valid      = (r_state == LSU_RESP);
  assign rsp_rdata      = r_rdata;
  assign rsp_d_select   = r_addr[1:0];
  assign rsp_funct3     = r_funct3;
  assign rsp_misaligned = rsp_valid & r_mis;
  assign rsp_illegal    = rsp_valid & r_ill;

endmodule
